// File: rtl/gated_down_counter_pkg.sv
// Shared types and constants for the gated load-and-drain down-counter.
package gated_counter_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} gc_state_t;

   localparam int GC_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/gated_down_counter_if.sv
// Load handshake and status bundle between a producer and gated_down_counter.
interface gated_down_counter_if
   import gated_counter_pkg::*;
#(
   parameter int WIDTH = GC_DEFAULT_WIDTH
);

   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] count_out;
   logic             busy;
   logic             done;
   logic             clk_en_out;

   modport master (
      output load_valid,
      output load_value,
      input  load_ready,
      input  count_out,
      input  busy,
      input  done,
      input  clk_en_out
   );

   modport slave (
      input  load_valid,
      input  load_value,
      output load_ready,
      output count_out,
      output busy,
      output done,
      output clk_en_out
   );

endinterface

// File: rtl/gated_down_counter_cg.sv
// Latch-plus-AND clock gate; behavioural stand-in for the library ICG cell.
module clock_gate_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic gclk,
   output logic en_latched
);

   logic en_q;

   // Transparent while clk is low so the enable is stable across the high phase.
   always_latch begin
      if (!rst_n) begin
         en_q <= 1'b0;
      end else if (!clk) begin
         en_q <= en;
      end
   end

   assign gclk       = clk & en_q;
   assign en_latched = en_q;

endmodule

// File: rtl/gated_down_counter.sv
// Loadable down-counter whose count/stored registers run on a gated clock.
//
//  state | meaning
//  IDLE  | waiting for a load; load_ready high, count regs not clocked
//  RUN   | decrementing count_out once per clock
//  DONE  | count reached zero; done pulses for this single cycle
module gated_down_counter
   import gated_counter_pkg::*;
#(
   parameter int WIDTH       = GC_DEFAULT_WIDTH,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   gated_down_counter_if.slave  bus
);

   gc_state_t        state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] stored_q, stored_d;
   logic             fire;
   logic             reload_ok;
   logic             gate_en;
   logic             gclk;
   logic             en_latched;

   assign fire      = bus.load_valid && (state_q == IDLE);
   assign reload_ok = AUTO_RELOAD && (stored_q != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (fire) begin
               state_d = (bus.load_value != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            if (count_q == WIDTH'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = reload_ok ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      count_d  = count_q;
      stored_d = stored_q;
      case (state_q)
         IDLE: begin
            if (fire) begin
               count_d  = bus.load_value;
               stored_d = bus.load_value;
            end
         end
         RUN:     count_d = count_q - WIDTH'(1);
         DONE: begin
            if (reload_ok) begin
               count_d = stored_q;
            end
         end
         default: count_d = count_q;
      endcase
   end

   // Count registers only need a clock edge when they actually change.
   assign gate_en = fire || (state_q == RUN) || ((state_q == DONE) && reload_ok);

   clock_gate_cell u_cg (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (gate_en),
      .gclk       (gclk),
      .en_latched (en_latched)
   );

   always_ff @(posedge gclk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         stored_q <= '0;
      end else begin
         count_q  <= count_d;
         stored_q <= stored_d;
      end
   end

   always_comb begin
      bus.load_ready = (state_q == IDLE);
      bus.busy       = (state_q == RUN) || (state_q == DONE);
      bus.done       = (state_q == DONE);
      bus.count_out  = count_q;
      bus.clk_en_out = en_latched;
   end

endmodule

// File: tb/tb_gated_down_counter.sv
// Randomised and directed bench for gated_down_counter, with and without auto-reload.
module tb_gated_down_counter;

   localparam int W = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   gated_down_counter_if #(.WIDTH(W)) bus0 ();
   gated_down_counter_if #(.WIDTH(W)) bus1 ();

   gated_down_counter #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   gated_down_counter #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   int total = 0;
   int bad   = 0;

   // Reference: queue of counts still to be shown after each edge; empty means idle.
   int q0[$];
   int q1[$];
   int stored0 = 0;
   int stored1 = 0;
   int gclk_edges = 0;

   always @(posedge dut0.gclk) gclk_edges++;

   task automatic check_eq(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive(input bit v, input int val);
      bus0.load_valid = v;
      bus0.load_value = W'(val);
      bus1.load_valid = v;
      bus1.load_value = W'(val);
   endtask

   task automatic model_edge(input int idx, input bit ar, input bit v, input int val,
                             output int en);
      int q[$];
      int st;
      int p;
      if (idx == 0) begin q = q0; st = stored0; end
      else          begin q = q1; st = stored1; end
      en = 0;
      if (q.size() == 0) begin
         if (v) begin
            st = val;
            en = 1;
            for (int c = val; c >= 1; c--) q.push_back(c);
            q.push_back(0);
         end
      end else begin
         p = q.pop_front();
         if (p != 0) begin
            en = 1;
         end else if (ar && st != 0) begin
            en = 1;
            for (int c = st; c >= 1; c--) q.push_back(c);
            q.push_back(0);
         end
      end
      if (idx == 0) begin q0 = q; stored0 = st; end
      else          begin q1 = q; stored1 = st; end
   endtask

   task automatic check_outs(input string tag, input int idx, input int cnt, input bit dn,
                             input bit by, input bit rd, input bit ce, input int en);
      int q[$];
      int e_cnt;
      bit active;
      if (idx == 0) q = q0; else q = q1;
      active = (q.size() != 0);
      e_cnt  = active ? q[0] : 0;
      check_eq({tag, ".count"}, cnt, e_cnt);
      check_eq({tag, ".done"},  int'(dn), int'(active && e_cnt == 0));
      check_eq({tag, ".busy"},  int'(by), int'(active));
      check_eq({tag, ".ready"}, int'(rd), int'(!active));
      check_eq({tag, ".clken"}, int'(ce), en);
   endtask

   // Entered just after a falling edge; returns at the next falling edge.
   task automatic tick(input bit v, input int val);
      int en0, en1;
      drive(v, val);
      @(posedge clk);
      model_edge(0, 1'b0, v, val, en0);
      model_edge(1, 1'b1, v, val, en1);
      #1;
      check_outs("ar0", 0, int'(bus0.count_out), bus0.done, bus0.busy, bus0.load_ready,
                 bus0.clk_en_out, en0);
      check_outs("ar1", 1, int'(bus1.count_out), bus1.done, bus1.busy, bus1.load_ready,
                 bus1.clk_en_out, en1);
      @(negedge clk);
   endtask

   task automatic do_reset();
      drive(1'b0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst.count0", int'(bus0.count_out), 0);
      check_eq("rst.count1", int'(bus1.count_out), 0);
      check_eq("rst.done0",  int'(bus0.done), 0);
      check_eq("rst.done1",  int'(bus1.done), 0);
      check_eq("rst.busy1",  int'(bus1.busy), 0);
      check_eq("rst.ready0", int'(bus0.load_ready), 1);
      check_eq("rst.clken1", int'(bus1.clk_en_out), 0);
      q0.delete();
      q1.delete();
      stored0 = 0;
      stored1 = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      drive(1'b0, 0);
      @(negedge clk);
      do_reset();

      // idle after reset: the gated clock must stay quiet
      gclk_edges = 0;
      for (int i = 0; i < 20; i++) tick(1'b0, 0);
      check_eq("idle.gclk_edges", gclk_edges, 0);
      check_eq("idle.clken", int'(bus0.clk_en_out), 0);

      // enable must be latched while clk is still low, ahead of the rising edge
      drive(1'b1, 4);
      #1;
      check_eq("early.clken", int'(bus0.clk_en_out), 1);
      tick(1'b1, 4);
      for (int i = 0; i < 9; i++) tick(1'b0, 0);

      do_reset();
      tick(1'b1, 0);
      for (int i = 0; i < 4; i++) tick(1'b0, 0);

      // 2 offered mid-run must wait until idle
      tick(1'b1, 7);
      for (int i = 0; i < 14; i++) tick(1'b1, 2);
      for (int i = 0; i < 4; i++) tick(1'b0, 0);

      // reload run then reset mid-count
      do_reset();
      tick(1'b1, 3);
      for (int i = 0; i < 10; i++) tick(1'b0, 0);
      do_reset();
      for (int i = 0; i < 3; i++) tick(1'b0, 0);

      // full-range load, no wrap after reaching zero
      tick(1'b1, 15);
      for (int i = 0; i < 20; i++) tick(1'b0, 0);

      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 79) == 0) begin
            do_reset();
         end else begin
            tick($urandom_range(0, 2) == 0, int'($urandom_range(0, 15)));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
